// File: rtl/csi2_lane_sequencer.sv
// Single-lane CSI-2 packet framer behind an HS byte receiver; CRC check built only with CSI2_CRC_CHECK_EN.
// Latency: every output is registered one cycle after the rx_enable (or gap expiry) that causes it.
// Backpressure: none; bytes are consumed as they arrive and rx_reset re-arms the receiver after each packet.
module csi2_lane_sequencer #(
    parameter int unsigned RESET_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_enable,
    output logic        rx_reset,
    output logic [7:0]  data_id,
    output logic [15:0] word_count,
    output logic        short_valid,
    output logic [7:0]  payload,
    output logic        payload_valid,
    output logic        packet_done,
    output logic        error
);

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_FOOTER, S_FLUSH} state_t;

    localparam logic [7:0] GAP_LAST   = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(RESET_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic        ftr_cnt_q, ftr_cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        rx_reset_q, rx_reset_d;
    logic [7:0]  data_id_q, data_id_d;
    logic [15:0] word_count_q, word_count_d;
    logic        short_valid_q, short_valid_d;
    logic [7:0]  payload_q, payload_d;
    logic        payload_valid_q, payload_valid_d;
    logic        packet_done_q, packet_done_d;
    logic        error_q, error_d;
    logic        gap_active, timeout, go_flush;

`ifdef CSI2_CRC_CHECK_EN
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_lo_q, crc_lo_d;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
            else             r = r >> 1;
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_d         = state_q;
        hdr_cnt_d       = hdr_cnt_q;
        byte_cnt_d      = byte_cnt_q;
        ftr_cnt_d       = ftr_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        rx_reset_d      = rx_reset_q;
        data_id_d       = data_id_q;
        word_count_d    = word_count_q;
        payload_d       = payload_q;
        short_valid_d   = 1'b0;
        payload_valid_d = 1'b0;
        packet_done_d   = 1'b0;
        error_d         = 1'b0;
        go_flush        = 1'b0;
`ifdef CSI2_CRC_CHECK_EN
        crc_d           = crc_q;
        crc_lo_d        = crc_lo_q;
`endif
        // A byte landing on the expiry cycle clears the gap instead of aborting.
        gap_active = (state_q == S_HEADER) || (state_q == S_PAYLOAD) || (state_q == S_FOOTER);
        timeout    = gap_active && !rx_enable && (gap_q >= GAP_LAST);
        gap_d      = 8'd0;
        if (gap_active && !rx_enable && (gap_q < GAP_LAST)) gap_d = gap_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                rx_reset_d = 1'b0;
                if (rx_enable) begin
                    data_id_d = rx_data;
                    hdr_cnt_d = 2'd1;
                    state_d   = S_HEADER;
                end
            end
            S_HEADER: begin
                if (rx_enable) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    case (hdr_cnt_q)
                        2'd1: word_count_d[7:0]  = rx_data;
                        2'd2: word_count_d[15:8] = rx_data;
                        default: begin
                            if (data_id_q[5:0] <= 6'h0F) begin
                                short_valid_d = 1'b1;
                                go_flush      = 1'b1;
                            end else if (word_count_q == 16'd0) begin
                                ftr_cnt_d = 1'b0;
                                state_d   = S_FOOTER;
                            end else begin
                                byte_cnt_d = word_count_q;
                                state_d    = S_PAYLOAD;
                            end
`ifdef CSI2_CRC_CHECK_EN
                            crc_d = 16'hFFFF;
`endif
                        end
                    endcase
                end else if (timeout) begin
                    error_d  = 1'b1;
                    go_flush = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (rx_enable) begin
                    payload_d       = rx_data;
                    payload_valid_d = 1'b1;
                    byte_cnt_d      = byte_cnt_q - 16'd1;
`ifdef CSI2_CRC_CHECK_EN
                    crc_d = crc16_byte(crc_q, rx_data);
`endif
                    if (byte_cnt_q == 16'd1) begin
                        ftr_cnt_d = 1'b0;
                        state_d   = S_FOOTER;
                    end
                end else if (timeout) begin
                    error_d  = 1'b1;
                    go_flush = 1'b1;
                end
            end
            S_FOOTER: begin
                if (rx_enable) begin
                    if (!ftr_cnt_q) begin
                        ftr_cnt_d = 1'b1;
`ifdef CSI2_CRC_CHECK_EN
                        crc_lo_d = rx_data;
`endif
                    end else begin
`ifdef CSI2_CRC_CHECK_EN
                        if ({rx_data, crc_lo_q} == crc_q) packet_done_d = 1'b1;
                        else                              error_d       = 1'b1;
`else
                        packet_done_d = 1'b1;
`endif
                        go_flush = 1'b1;
                    end
                end else if (timeout) begin
                    error_d  = 1'b1;
                    go_flush = 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    rx_reset_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go_flush) begin
            state_d     = S_FLUSH;
            rx_reset_d  = 1'b1;
            flush_cnt_d = FLUSH_LOAD;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            hdr_cnt_q       <= 2'd0;
            byte_cnt_q      <= 16'd0;
            ftr_cnt_q       <= 1'b0;
            gap_q           <= 8'd0;
            flush_cnt_q     <= 4'd0;
            rx_reset_q      <= 1'b1;
            data_id_q       <= 8'd0;
            word_count_q    <= 16'd0;
            short_valid_q   <= 1'b0;
            payload_q       <= 8'd0;
            payload_valid_q <= 1'b0;
            packet_done_q   <= 1'b0;
            error_q         <= 1'b0;
`ifdef CSI2_CRC_CHECK_EN
            crc_q           <= 16'hFFFF;
            crc_lo_q        <= 8'd0;
`endif
        end else begin
            state_q         <= state_d;
            hdr_cnt_q       <= hdr_cnt_d;
            byte_cnt_q      <= byte_cnt_d;
            ftr_cnt_q       <= ftr_cnt_d;
            gap_q           <= gap_d;
            flush_cnt_q     <= flush_cnt_d;
            rx_reset_q      <= rx_reset_d;
            data_id_q       <= data_id_d;
            word_count_q    <= word_count_d;
            short_valid_q   <= short_valid_d;
            payload_q       <= payload_d;
            payload_valid_q <= payload_valid_d;
            packet_done_q   <= packet_done_d;
            error_q         <= error_d;
`ifdef CSI2_CRC_CHECK_EN
            crc_q           <= crc_d;
            crc_lo_q        <= crc_lo_d;
`endif
        end
    end

    assign rx_reset      = rx_reset_q;
    assign data_id       = data_id_q;
    assign word_count    = word_count_q;
    assign short_valid   = short_valid_q;
    assign payload       = payload_q;
    assign payload_valid = payload_valid_q;
    assign packet_done   = packet_done_q;
    assign error         = error_q;

endmodule
